// File: rtl/ni_stream_wr_pkg.sv
// Shared types and constants for the stream-to-Wishbone burst writer.
package ni_stream_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int unsigned TIMEOUT_LIMIT = 255;

  // Smallest of three unsigned quantities; used to size each burst.
  function automatic int unsigned min3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/ni_stream_wb_writer_if.sv
// Wishbone burst-write bus between the stream writer (master) and the NI buffer port (slave).
interface ni_stream_wb_writer_if #(
  parameter int unsigned Dw   = 32,
  parameter int unsigned Aw   = 10,
  parameter int unsigned TAGw = 3,
  parameter int unsigned SELw = 4
);
  logic [Dw-1:0]   dat_o;
  logic [Aw-1:0]   addr_o;
  logic [SELw-1:0] sel_o;
  logic [TAGw-1:0] cti_o;
  logic            stb_o;
  logic            cyc_o;
  logic            we_o;
  logic            ack_i;

  modport master (
    output dat_o, addr_o, sel_o, cti_o, stb_o, cyc_o, we_o,
    input  ack_i
  );

  modport slave (
    input  dat_o, addr_o, sel_o, cti_o, stb_o, cyc_o, we_o,
    output ack_i
  );
endinterface

// File: rtl/ni_stream_wr_hold.sv
// One-entry holding register between the stream port and the Wishbone data bus.
module ni_stream_wr_hold #(
  parameter int unsigned Dw = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          drain,
  input  logic          flush,
  input  logic [Dw-1:0] d,
  output logic [Dw-1:0] q,
  output logic          hv
);

  // Load wins over drain so a word taken on the same edge as an ack refills the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hv <= 1'b0;
      q  <= '0;
    end else if (flush) begin
      hv <= 1'b0;
    end else if (load) begin
      hv <= 1'b1;
      q  <= d;
    end else if (drain) begin
      hv <= 1'b0;
    end
  end

endmodule

// File: rtl/ni_stream_wb_writer.sv
// Stream-to-Wishbone burst writer feeding an NI send buffer with incrementing-address bursts.
// Optional ack timeout with sticky error: define NI_STREAM_WR_TIMEOUT_EN.
module ni_stream_wb_writer
  import ni_stream_wr_pkg::*;
#(
  parameter int unsigned Dw             = 32,
  parameter int unsigned Aw             = 10,
  parameter int unsigned LENw           = 10,
  parameter int unsigned MAX_BURST_SIZE = 256,
  parameter int unsigned TAGw           = 3,
  parameter int unsigned SELw           = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [Aw-1:0]         start_addr,
  input  logic [LENw-1:0]       length,
  input  logic [Dw-1:0]         s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  ni_stream_wb_writer_if.master wb
);

  localparam int unsigned BW    = $clog2(MAX_BURST_SIZE + 1);
  localparam int unsigned DEPTH = 1 << Aw;

  state_t          state_q, state_d;
  logic [LENw-1:0] accept_left_q, write_left_q;
  logic [BW-1:0]   beat_left_q;
  logic [Aw-1:0]   addr_q;
  logic [Aw-1:0]   burst_addr;
  logic [LENw-1:0] burst_words;
  logic [BW-1:0]   beat_len;
  logic [Dw-1:0]   hold_q;
  logic            hv;
  logic            cyc, stb, ack_fire, take, flush;
  logic            last_beat, last_word;
  logic            accept_start, load_beats, timeout_hit;

  assign accept_start = (state_q == ST_IDLE) && start;
  assign cyc          = (state_q == ST_BURST);
  assign stb          = cyc && hv;
  assign ack_fire     = stb && wb.ack_i;
  assign busy         = (state_q == ST_BURST) || (state_q == ST_GAP);
  assign done         = (state_q == ST_DONE);
  assign s_ready      = busy && (accept_left_q != '0) && (!hv || ack_fire);
  assign take         = s_valid && s_ready;
  assign flush        = (state_q == ST_DONE);
  assign last_beat    = (beat_left_q == BW'(1));
  assign last_word    = (write_left_q == LENw'(1));

  // A new burst is sized from the command in IDLE, otherwise from the running counters.
  assign burst_addr  = (state_q == ST_IDLE) ? start_addr : addr_q;
  assign burst_words = (state_q == ST_IDLE) ? length : write_left_q;
  assign beat_len    = BW'(min3(32'(burst_words), MAX_BURST_SIZE,
                                DEPTH - 32'(burst_addr)));

  ni_stream_wr_hold #(.Dw(Dw)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (take),
    .drain (ack_fire),
    .flush (flush),
    .d     (s_data),
    .q     (hold_q),
    .hv    (hv)
  );

`ifdef NI_STREAM_WR_TIMEOUT_EN
  logic [7:0] tmo_q;
  logic       error_q;

  assign timeout_hit = stb && !wb.ack_i && (tmo_q == 8'(TIMEOUT_LIMIT - 1));
  assign error       = error_q;

  // Counts stalled strobe cycles; a stream-side wait state holds the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      if (!cyc || ack_fire) begin
        tmo_q <= '0;
      end else if (stb) begin
        tmo_q <= tmo_q + 8'd1;
      end
      if (timeout_hit) begin
        error_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_beats = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_BURST;
            load_beats = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (timeout_hit) begin
          state_d = ST_DONE;
        end else if (ack_fire && last_beat) begin
          state_d = last_word ? ST_DONE : ST_GAP;
        end
      end
      ST_GAP: begin
        state_d    = ST_BURST;
        load_beats = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transfer counters and address; the command is only captured from IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accept_left_q <= '0;
      write_left_q  <= '0;
      addr_q        <= '0;
      beat_left_q   <= '0;
    end else begin
      if (accept_start) begin
        accept_left_q <= length;
        write_left_q  <= length;
        addr_q        <= start_addr;
      end else begin
        if (take) begin
          accept_left_q <= accept_left_q - LENw'(1);
        end
        if (ack_fire) begin
          write_left_q <= write_left_q - LENw'(1);
          addr_q       <= addr_q + Aw'(1);
        end
      end
      if (load_beats) begin
        beat_left_q <= beat_len;
      end else if (ack_fire) begin
        beat_left_q <= beat_left_q - BW'(1);
      end
    end
  end

  assign wb.cyc_o  = cyc;
  assign wb.stb_o  = stb;
  assign wb.we_o   = cyc;
  assign wb.sel_o  = cyc ? {SELw{1'b1}} : '0;
  assign wb.dat_o  = hold_q;
  assign wb.addr_o = addr_q;
  assign wb.cti_o  = !cyc     ? TAGw'(CTI_CLASSIC) :
                     last_beat ? TAGw'(CTI_END)    : TAGw'(CTI_INC);

endmodule
